// File: rtl/pio_pixel_feeder.sv
// Pixel frame feeder for a WS2812 PIO state machine.
// Holds NUM_PIXELS GRB pixels and, on start, pushes each one as
// {pixel, 8'h00} into the TX FIFO of machine MINDEX, throttled by the FIFO
// full flag. The feeder then idles for the WS2812 latch gap and pulses
// frame_done.
//
// Handshake: a word is transferred in exactly the cycle where action==4
// (PUSH). The PIO side has no ready signal; full==1 stands in for !ready and
// blocks the push. action is combinational from the current state and full,
// so a push lands in the first cycle full is seen low.
module pio_pixel_feeder #(
  parameter int NUM_PIXELS   = 16,
  parameter int MINDEX       = 0,
  parameter int PUSH_GAP     = 2,
  parameter int LATCH_CYCLES = 1400,
  localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          start,
  input  logic          full,
  output logic [31:0]   din,
  output logic [3:0]    action,
  output logic [1:0]    mindex,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    stall_cnt,
  output logic [2:0]    state_dbg
);

  localparam int CMAX = (LATCH_CYCLES > PUSH_GAP) ? LATCH_CYCLES : PUSH_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [AW:0]   NP_W      = (AW+1)'(NUM_PIXELS);
  localparam logic [AW-1:0] LAST_PTR  = AW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(PUSH_GAP - 2);
  localparam logic [CW-1:0] LTCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [3:0]    ACT_PUSH  = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PUSH  = 3'd2,
    S_GAP   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [7:0]    stall_nx;
  logic [31:0]   din_q;
  logic [23:0]   rd_data;
  logic          push;

  logic [23:0] mem [NUM_PIXELS];

  // Pixel buffer: write port open at all times, read captured only in FETCH
  // so the word stays stable while a push is held off by full.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < NP_W)) mem[wr_addr] <= wr_data;
    if (state == S_FETCH) rd_data <= mem[ptr];
  end

  // Control state and registered outputs; reset aborts a frame immediately.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= '0;
      stall_cnt <= '0;
      din_q     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ptr       <= ptr_nx;
      stall_cnt <= stall_nx;
      if (push) din_q <= {rd_data, 8'h00};
    end
  end

  // Next-state, push decision, stall counting and frame_done pulse.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ptr_nx     = ptr;
    stall_nx   = stall_cnt;
    push       = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_FETCH;
          ptr_nx   = '0;
          stall_nx = '0;
        end
      end
      S_FETCH: state_nx = S_PUSH;
      S_PUSH: begin
        if (full) begin
          if (stall_cnt != 8'hFF) stall_nx = stall_cnt + 8'd1;
        end else begin
          push     = 1'b1;
          state_nx = S_GAP;
          cnt_nx   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
          if (ptr == LAST_PTR) begin
            state_nx = S_LATCH;
          end else begin
            ptr_nx   = ptr + AW'(1);
            state_nx = S_FETCH;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt == LTCH_LAST) begin
          frame_done = 1'b1;
          state_nx   = S_IDLE;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign action    = push ? ACT_PUSH : 4'd0;
  assign din       = push ? {rd_data, 8'h00} : din_q;
  assign busy      = (state != S_IDLE);
  assign mindex    = 2'(MINDEX);
  assign state_dbg = state;

endmodule

// File: tb/tb_pio_pixel_feeder.sv
// Bench for pio_pixel_feeder: directed scenarios plus randomized frames,
// checked cycle by cycle against a timing/data model of the feeder.
module tb_pio_pixel_feeder;

  localparam int NUM_PIXELS   = 16;
  localparam int MINDEX       = 0;
  localparam int PUSH_GAP     = 2;
  localparam int LATCH_CYCLES = 1400;
  localparam int AW           = $clog2(NUM_PIXELS);
  localparam int FRAME_MIN    = NUM_PIXELS * (PUSH_GAP + 1) + LATCH_CYCLES;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          start;
  logic          full;
  logic [31:0]   din;
  logic [3:0]    action;
  logic [1:0]    mindex;
  logic          busy;
  logic          frame_done;
  logic [7:0]    stall_cnt;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pio_pixel_feeder #(
    .NUM_PIXELS(NUM_PIXELS), .MINDEX(MINDEX),
    .PUSH_GAP(PUSH_GAP), .LATCH_CYCLES(LATCH_CYCLES)
  ) dut (
    .clk(clk), .n_reset(n_reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .full(full), .din(din),
    .action(action), .mindex(mindex), .busy(busy), .frame_done(frame_done),
    .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // A frame is a list of NUM_PIXELS push opportunities. The first opens two
  // cycles after start is seen; each later one opens PUSH_GAP+1 cycles after
  // the previous push. The pixel is read from the buffer the cycle before its
  // opportunity opens. From the opportunity onward, every full cycle is a
  // stall and the first non-full cycle is the push. frame_done comes
  // PUSH_GAP-1+LATCH_CYCLES cycles after the last push.
  logic [23:0] m_buf [NUM_PIXELS];
  logic [31:0] exp_q [$];
  bit          m_active = 1'b0;
  int          m_left = 0, m_due = 0, m_done_at = 0, m_stall = 0;
  logic [31:0] m_last_din = '0;
  logic        exp_push;
  logic [31:0] w;

  // sample outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!n_reset) begin
      m_active   = 1'b0;
      m_stall    = 0;
      m_last_din = '0;
      exp_q.delete();
    end else begin
      exp_push = m_active && (m_left > 0) && (cyc >= m_due) && !full;
      check_eq("action", 32'(action), exp_push ? 32'd4 : 32'd0);
      check_eq("busy", 32'(busy), 32'(m_active));
      check_eq("frame_done", 32'(frame_done),
               32'(m_active && (m_left == 0) && (cyc == m_done_at)));
      check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (exp_push) begin
        if (exp_q.size() == 0) begin
          check_eq("exp_q_empty", 32'(exp_q.size()), 32'd1);
          w = m_last_din;
        end else begin
          w = exp_q.pop_front();
        end
        check_eq("din_push", din, w);
        m_last_din = w;
        m_left--;
        m_due = cyc + PUSH_GAP + 1;
        if (m_left == 0) m_done_at = cyc + PUSH_GAP - 1 + LATCH_CYCLES;
      end else begin
        check_eq("din_hold", din, m_last_din);
        if (m_active && (m_left > 0) && (cyc >= m_due) && full && (m_stall < 255))
          m_stall++;
      end
      if (m_active && (m_left > 0) && (cyc == m_due - 1))
        exp_q.push_back({m_buf[NUM_PIXELS - m_left], 8'h00});
      if (m_active && (m_left == 0) && (cyc == m_done_at)) begin
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        m_left   = NUM_PIXELS;
        m_due    = cyc + 2;
        m_stall  = 0;
        exp_q.delete();
      end
      if (wr_en && (int'(wr_addr) < NUM_PIXELS)) m_buf[wr_addr] = wr_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_frame(output int s_cyc);
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pushes(input int k);
    int n = 0;
    int t = 0;
    while (n < k && t < 5000) begin
      @(negedge clk);
      if (action == 4'd4) n++;
      t++;
    end
    if (n < k) check_eq("push_timeout", 32'(n), 32'(k));
    tick();
  endtask

  task automatic wait_done(input bit rnd, output int d_cyc);
    bit seen = 1'b0;
    int t = 0;
    d_cyc = -1;
    while (!seen && t < 4000) begin
      if (rnd) begin
        full    = ($urandom_range(0, 3) == 0);
        wr_en   = ($urandom_range(0, 7) == 0);
        wr_addr = AW'($urandom_range(0, NUM_PIXELS - 1));
        wr_data = 24'($urandom);
      end
      @(negedge clk);
      if (frame_done) begin
        seen  = 1'b1;
        d_cyc = cyc;
      end
      tick();
      t++;
    end
    full  = 1'b0;
    wr_en = 1'b0;
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int s_cyc, d_cyc;

  initial begin
    n_reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; full = 1'b0;
    repeat (3) tick();
    check_eq("rst_din", din, 32'd0);
    check_eq("rst_action", 32'(action), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("mindex", 32'(mindex), 32'(MINDEX));
    n_reset = 1'b1;
    tick();

    // 1: fixed pattern, no back-pressure, minimum frame time
    write_px(0, 24'h00FF00);
    for (int i = 1; i < NUM_PIXELS; i++) write_px(i, 24'hFF00FF);
    start_frame(s_cyc);
    wait_done(1'b0, d_cyc);
    check_eq("frame_time", 32'(d_cyc - s_cyc), 32'(FRAME_MIN));
    tick();

    // 2: full held for 10 cycles exactly over pixel 5's push opportunity
    start_frame(s_cyc);
    wait_pushes(5);
    tick(); tick();
    full = 1'b1;
    repeat (10) tick();
    full = 1'b0;
    wait_done(1'b0, d_cyc);
    check_eq("stall_10", 32'(stall_cnt), 32'd10);
    check_eq("frame_time_stall", 32'(d_cyc - s_cyc), 32'(FRAME_MIN + 10));
    tick();

    // 3: second start 20 cycles into a frame is ignored
    start_frame(s_cyc);
    repeat (19) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, d_cyc);
    check_eq("frame_time_ign", 32'(d_cyc - s_cyc), 32'(FRAME_MIN));
    tick();

    // 5: rewrite px15 in the cycle pixel 3 is pushed
    start_frame(s_cyc);
    wait_pushes(3);
    tick(); tick();
    write_px(15, 24'h123456);
    wait_done(1'b0, d_cyc);
    tick();

    // 4: asynchronous reset in pixel 7's push cycle, then a clean frame
    start_frame(s_cyc);
    wait_pushes(7);
    tick(); tick();
    #2 n_reset = 1'b0;
    #1;
    check_eq("arst_action", 32'(action), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_din", din, 32'd0);
    check_eq("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    tick();
    start_frame(s_cyc);
    wait_done(1'b0, d_cyc);
    check_eq("frame_time_rst", 32'(d_cyc - s_cyc), 32'(FRAME_MIN));
    tick();

    // 6: 300 full cycles saturate stall_cnt; next start clears it
    start_frame(s_cyc);
    wait_pushes(1);
    full = 1'b1;
    repeat (300) tick();
    full = 1'b0;
    wait_done(1'b0, d_cyc);
    check_eq("stall_sat", 32'(stall_cnt), 32'd255);
    start_frame(s_cyc);
    check_eq("stall_clear", 32'(stall_cnt), 32'd0);
    wait_done(1'b0, d_cyc);
    tick();

    // randomized frames: random pixels, random full, random writes while busy
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NUM_PIXELS; i++) write_px(i, 24'($urandom));
      start_frame(s_cyc);
      wait_done(1'b1, d_cyc);
      tick();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
